// File: rtl/data_memory_pkg.sv
// Shared definitions for the line-based data memory and its dcache client.
package data_memory_pkg;
    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/data_memory_if.sv
// Request/response bundle between the dcache (master) and data memory (slave).
interface data_memory_if;
    import data_memory_pkg::*;

    logic              enable_i;
    logic              write_i;
    logic [ADDR_W-1:0] addr_i;
    logic [LINE_W-1:0] data_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;
    logic              busy_o;

    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  ack_o, data_o, busy_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output ack_o, data_o, busy_o
    );
endinterface

// File: rtl/data_memory_line_array.sv
// Single-port synchronous line store; read data is held until the next read.
module dmem_line_array
    import data_memory_pkg::*;
#(
    parameter int LINE_NUM = 512,
    localparam int IDX_W   = $clog2(LINE_NUM)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);
    logic [LINE_W-1:0] mem_q [LINE_NUM];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[idx_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_memory.sv
// Fixed-latency line memory: one transaction at a time, ack_o LATENCY cycles after acceptance.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int LATENCY  = 10,
    parameter int LINE_NUM = 512
) (
    input  logic          clk_i,
    input  logic          rst_i,
    data_memory_if.slave  bus
);
    localparam int IDX_W = $clog2(LINE_NUM);

    state_e            state_q;
    logic [7:0]        cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              wr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              ack_q;
    logic              rd_vld_q;
    logic              arr_we;
    logic              arr_re;
    logic [LINE_W-1:0] arr_rdata;

    // The array read is launched one cycle early so the line is visible in the DONE cycle.
    assign arr_re = rst_i && (state_q == WAIT) && (cnt_q == 8'd1) && !wr_q;
    assign arr_we = rst_i && (state_q == DONE) && wr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable_i) begin
                        idx_q   <= bus.addr_i[OFFSET_W +: IDX_W];
                        wr_q    <= bus.write_i;
                        wdata_q <= bus.data_i;
                        cnt_q   <= 8'(LATENCY - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                        if (!wr_q) rd_vld_q <= 1'b1;
                    end
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dmem_line_array #(.LINE_NUM(LINE_NUM)) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    // Array contents are unreset, so data_o stays zero until the first read completes.
    assign bus.data_o = rd_vld_q ? arr_rdata : '0;
    assign bus.ack_o  = ack_q;
    assign bus.busy_o = (state_q != IDLE);
endmodule
